frame_capture: RTL and testbench

- Capture stage between the DVI/TMDS decoder and the image-RAM write FIFO (iram_* path) inside Hdmi2usb.
- Continuously measures the active resolution of the incoming decoded pixel stream and reports it as resx/resy.
- On a start request, writes exactly one complete active frame of 24-bit RGB pixels into the FIFO, honouring almost-full, with busy/done handshaking to the controller.

---
 rtl/hdmi2usb_pkg.sv | 15 +
 rtl/res_measure.sv | 72 +++++++
 rtl/frame_capture.sv | 107 ++++++++++
 tb/tb_frame_capture.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi2usb_pkg.sv
// Shared types and default widths for the Hdmi2usb frame capture path.
package hdmi2usb_pkg;

    localparam int DATA_W = 24;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/res_measure.sv
// Active-resolution measurement of the decoded pixel stream; also provides
// the qualified vsync rising edge used by the capture FSM.
module res_measure #(
    parameter int CNT_W = hdmi2usb_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_de,
    input  logic             pix_vsync,
    output logic             vs_rise,
    output logic [CNT_W-1:0] resx,
    output logic [CNT_W-1:0] resy,
    output logic             res_valid
);
    import hdmi2usb_pkg::*;

    localparam logic [CNT_W-1:0] SAT = '1;

    logic             de_prev;
    logic             vs_prev;
    logic             de_fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] line_w;

    // Edge history only advances on valid cycles, so gaps never fake an edge.
    assign vs_rise = pix_valid && pix_vsync && !vs_prev;
    assign de_fall = pix_valid && !pix_de && de_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else if (pix_valid) begin
            de_prev <= pix_de;
            vs_prev <= pix_vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            line_w <= '0;
        end else if (de_fall) begin
            line_w <= hcnt;
            hcnt   <= '0;
        end else if (pix_valid && pix_de && hcnt != SAT) begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    // A frame with no completed lines leaves the last measurement in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt      <= '0;
            resx      <= '0;
            resy      <= '0;
            res_valid <= 1'b0;
        end else if (vs_rise) begin
            if (vcnt != '0) begin
                resx      <= line_w;
                resy      <= vcnt;
                res_valid <= 1'b1;
            end
            vcnt <= '0;
        end else if (de_fall && vcnt != SAT) begin
            vcnt <= vcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_capture.sv
// Captures one active frame into the image-RAM FIFO on request and reports
// the measured resolution. FRAME_CAPTURE_PIXCNT_EN adds the pix_count output.
module frame_capture #(
    parameter int DATA_W = hdmi2usb_pkg::DATA_W,
    parameter int CNT_W  = hdmi2usb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_de,
    input  logic              pix_hsync,
    input  logic              pix_vsync,
    input  logic [DATA_W-1:0] pix_rgb,
    input  logic              start,
    input  logic              iram_fifo_afull,
    output logic [DATA_W-1:0] iram_wdata,
    output logic              iram_wren,
    output logic [CNT_W-1:0]  resx,
    output logic [CNT_W-1:0]  resy,
    output logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef FRAME_CAPTURE_PIXCNT_EN
    ,
    output logic [31:0]       pix_count
`endif
);
    import hdmi2usb_pkg::*;

    cap_state_t state;
    cap_state_t state_nxt;
    logic       vs_rise;
    logic       arm;
    logic       cand;
    logic       accept;
    logic       unused_hsync;

    // Line timing comes from de alone; hsync is carried for completeness.
    assign unused_hsync = pix_hsync;

    res_measure #(.CNT_W(CNT_W)) u_res_measure (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_de    (pix_de),
        .pix_vsync (pix_vsync),
        .vs_rise   (vs_rise),
        .resx      (resx),
        .resy      (resy),
        .res_valid (res_valid)
    );

    // Stream handshake: pix_valid qualifies every pix_* input; there is no
    // ready, so a candidate seen while iram_fifo_afull is high is dropped.
    assign arm    = (state == ST_IDLE) && start;
    assign cand   = (state == ST_CAPTURE) && pix_valid && pix_de;
    assign accept = cand && !iram_fifo_afull;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start)   state_nxt = ST_ARM;
            ST_ARM:     if (vs_rise) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (vs_rise) state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_ARM, ST_CAPTURE: busy = 1'b1;
            ST_DONE:            done = 1'b1;
            default:            ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iram_wren  <= 1'b0;
            iram_wdata <= '0;
            overflow   <= 1'b0;
        end else begin
            iram_wren <= accept;
            if (accept) iram_wdata <= pix_rgb;
            if (arm)                        overflow <= 1'b0;
            else if (cand && iram_fifo_afull) overflow <= 1'b1;
        end
    end

`ifdef FRAME_CAPTURE_PIXCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pix_count <= '0;
        else if (arm)    pix_count <= '0;
        else if (accept) pix_count <= pix_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: frame-level stimulus with a behavioural model of
// resolution, capture window, drops and done pulses.
module tb_frame_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_de = 1'b0;
    logic        pix_hsync = 1'b0;
    logic        pix_vsync = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic        start = 1'b0;
    logic        iram_fifo_afull = 1'b0;
    logic [23:0] iram_wdata;
    logic        iram_wren;
    logic [15:0] resx;
    logic [15:0] resy;
    logic        res_valid;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef FRAME_CAPTURE_PIXCNT_EN
    logic [31:0] pix_count;
`endif

    frame_capture dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pix_de          (pix_de),
        .pix_hsync       (pix_hsync),
        .pix_vsync       (pix_vsync),
        .pix_rgb         (pix_rgb),
        .start           (start),
        .iram_fifo_afull (iram_fifo_afull),
        .iram_wdata      (iram_wdata),
        .iram_wren       (iram_wren),
        .resx            (resx),
        .resy            (resy),
        .res_valid       (res_valid),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
`ifdef FRAME_CAPTURE_PIXCNT_EN
        ,
        .pix_count       (pix_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int frame_no = 0;
    logic [23:0] exp_q[$];

    // Behavioural model state
    bit m_armed = 0;
    bit m_capt = 0;
    bit m_done_flag = 0;
    int m_lines = 0;
    int m_linew = 0;
    int cur_w = 0;
    int exp_resx = 0;
    int exp_resy = 0;
    bit exp_rv = 0;
    bit exp_ovf = 0;
    int exp_cnt = 0;
    int exp_done = 0;
    int got_done = 0;
    int cyc = 0;
    int start_at = -1;

    logic [23:0] last_wdata = '0;
    logic [23:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s frame %0d: got %0h expected %0h", tag, frame_no, got, expv);
        end
    endtask

    // Write scoreboard: every write must match the next expected pixel in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_wdata = '0;
        end else begin
            if (done) got_done++;
            n_vec++;
            if (iram_wren) begin
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_write frame %0d: got %0h expected none", frame_no, iram_wdata);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    assert (iram_wdata === mon_e) else begin
                        n_err++;
                        $error("FAIL wdata frame %0d: got %0h expected %0h", frame_no, iram_wdata, mon_e);
                    end
                end
                last_wdata = iram_wdata;
            end else begin
                assert (iram_wdata === last_wdata) else begin
                    n_err++;
                    $error("FAIL wdata_hold frame %0d: got %0h expected %0h", frame_no, iram_wdata, last_wdata);
                end
            end
        end
    end

    // One stream cycle: drive inputs, advance the model, cross one clock edge.
    task automatic tick(input bit v, input bit de, input bit hs, input bit vs,
                        input logic [23:0] rgb, input bit af,
                        input bit ev_vs, input bit ev_pix, input bit ev_eol);
        bit in_done;
        bit go;
        pix_valid = v;
        pix_de = de;
        pix_hsync = hs;
        pix_vsync = vs;
        pix_rgb = rgb;
        iram_fifo_afull = ev_pix ? af : 1'($urandom_range(0, 1));
        start = (cyc == start_at);
        in_done = m_done_flag;
        m_done_flag = 0;
        go = start && !m_armed && !m_capt && !in_done;
        if (ev_pix && m_capt) begin
            if (af) exp_ovf = 1;
            else begin
                exp_q.push_back(rgb);
                exp_cnt++;
            end
        end
        if (ev_eol) begin
            m_lines++;
            m_linew = cur_w;
        end
        if (ev_vs) begin
            if (m_lines > 0) begin
                exp_resx = m_linew;
                exp_resy = m_lines;
                exp_rv = 1;
            end
            m_lines = 0;
            if (m_capt) begin
                m_capt = 0;
                m_done_flag = 1;
                exp_done++;
            end else if (m_armed) begin
                m_armed = 0;
                m_capt = 1;
            end
        end
        if (go) begin
            m_armed = 1;
            exp_ovf = 0;
            exp_cnt = 0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wren"}, 32'(iram_wren), 0);
        chk({tag, "_wdata"}, 32'(iram_wdata), 0);
        chk({tag, "_resx"}, 32'(resx), 0);
        chk({tag, "_resy"}, 32'(resy), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
`ifdef FRAME_CAPTURE_PIXCNT_EN
        chk({tag, "_pix_count"}, pix_count, 0);
`endif
    endtask

    task automatic mid_reset();
        #5;
        chk("writes_before_reset", 32'(exp_cnt), 10);
        chk("drained_before_reset", 32'(exp_q.size()), 0);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        start = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        exp_q.delete();
        m_armed = 0;
        m_capt = 0;
        m_done_flag = 0;
        m_lines = 0;
        exp_resx = 0;
        exp_resy = 0;
        exp_rv = 0;
        exp_ovf = 0;
        exp_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Frame: 2 blanking lines (vsync on the first 2 cycles), then h active lines
    // of w pixels followed by 4 blanking cycles each.
    task automatic send_frame(input int w, input int h, input int st, input bit gaps,
                              input int rst_pix, input int n_drop);
        int line_len;
        int pix_idx;
        int k;
        int p;
        logic [7:0] seed;
        bit drop[];
        frame_no++;
        line_len = w + 4;
        pix_idx = 0;
        seed = 8'($urandom);
        drop = new[w * h];
        k = 0;
        while (k < n_drop) begin
            p = $urandom_range(0, w * h - 1);
            if (!drop[p]) begin
                drop[p] = 1;
                k++;
            end
        end
        cyc = 0;
        start_at = st;
        cur_w = w;
        for (int l = 0; l < 2; l++)
            for (int x = 0; x < line_len; x++)
                tick(1, 0, x >= line_len - 2, (l == 0) && (x < 2), 24'($urandom), 0,
                     (l == 0) && (x == 0), 0, 0);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (pix_idx == rst_pix) begin
                    mid_reset();
                    start_at = -1;
                    return;
                end
                if (gaps)
                    repeat ($urandom_range(0, 2))
                        tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 24'($urandom), 0, 0, 0, 0);
                tick(1, 1, 0, 0, {seed, 16'(pix_idx + 1)}, drop[pix_idx], 0, 1, 0);
                pix_idx++;
            end
            for (int x = 0; x < 4; x++)
                tick(1, 0, x >= 2, 0, 24'($urandom), 0, 0, 0, x == 0);
        end
        start_at = -1;
    endtask

    task automatic frame_checks();
        chk("resx", 32'(resx), exp_resx);
        chk("resy", 32'(resy), exp_resy);
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(m_armed || m_capt));
        chk("done_now", 32'(done), 0);
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("done_pulses", got_done, exp_done);
        chk("writes_pending", 32'(exp_q.size()), 0);
`ifdef FRAME_CAPTURE_PIXCNT_EN
        chk("pix_count", pix_count, exp_cnt);
`endif
    endtask

    initial begin
        int rw;
        int rh;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Resolution measurement only
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        chk("first_frame_res_valid", 32'(res_valid), 0);
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        chk("measured_resx", 32'(resx), 8);
        chk("measured_resy", 32'(resy), 4);
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();

        // Basic capture: start mid-frame, next frame captured
        send_frame(8, 4, 30, 0, -1, 0); frame_checks();
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        chk("basic_captured", 32'(exp_cnt), 32);

        // Back-pressure: 3 dropped candidates
        send_frame(8, 4, 30, 0, -1, 0); frame_checks();
        send_frame(8, 4, -1, 0, -1, 3); frame_checks();
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        chk("bp_written", 32'(exp_cnt), 29);
        chk("bp_overflow", 32'(overflow), 1);
        send_frame(8, 4, 5, 0, -1, 0); frame_checks();
        chk("overflow_cleared", 32'(overflow), 0);

        // start while capturing, start coinciding with vs_rise, start in ARM, gaps
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        send_frame(8, 4, 0, 0, -1, 0); frame_checks();
        send_frame(8, 4, 0, 0, -1, 0); frame_checks();
        chk("armed_after_vs_start", 32'(busy), 1);
        send_frame(8, 4, 0, 1, -1, 0); frame_checks();
        send_frame(8, 4, 10, 0, -1, 0); frame_checks();

        // Reset mid-capture, then a clean capture
        send_frame(8, 4, -1, 0, 10, 0); frame_checks();
        send_frame(8, 4, 30, 0, -1, 0); frame_checks();
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        send_frame(8, 4, -1, 0, -1, 0); frame_checks();
        chk("post_reset_captured", 32'(exp_cnt), 32);

        // Randomised frame size with gaps and random drops
        rw = $urandom_range(3, 12);
        rh = $urandom_range(2, 6);
        send_frame(rw, rh, 5, 0, -1, 0); frame_checks();
        send_frame(rw, rh, -1, 1, -1, $urandom_range(0, 2)); frame_checks();
        send_frame(rw, rh, -1, 0, -1, 0); frame_checks();
        chk("random_resx", 32'(resx), rw);
        chk("random_resy", 32'(resy), rh);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
